// File: rtl/aes_pkg.sv
// aes_pkg: shared AES constants, byte-serial FSM state encoding and ShiftRows position helper
package aes_pkg;
  localparam int AES_NB_BYTES = 16;
  typedef enum logic {COLLECT, HOLD} sr_state_e;
  // Byte k (row r = k[1:0], column c = k[3:2]) moves to column c -/+ r, with 2-bit wrap
  function automatic logic [3:0] sr_pos(input logic [3:0] k, input logic inv);
    logic [1:0] r;
    logic [1:0] c;
    r = k[1:0];
    c = inv ? k[3:2] + r : k[3:2] - r;
    return {c, r};
  endfunction
endpackage

// File: rtl/aes_shift_rows_ser.sv
// aes_shift_rows_ser: byte-serial forward/inverse ShiftRows into a 128-bit block with valid/ready on both sides
module aes_shift_rows_ser
  import aes_pkg::*;
(
  input  logic         i_Clk,
  input  logic         i_Rst,
  input  logic         i_Clear,
  input  logic         i_Byte_Valid,
  input  logic [7:0]   i_Byte,
  input  logic         i_Inv,
  output logic         o_Byte_Ready,
  output logic [127:0] o_Dout,
  output logic         o_Dout_Valid,
  input  logic         i_Dout_Ready
);
  sr_state_e   state_q;
  logic [3:0]  cnt_q;
  logic        mode_q;
  logic [7:0]  mem_q [AES_NB_BYTES];
  logic        acc;
  logic [15:0] we_d;
  assign o_Byte_Ready = state_q == COLLECT;
  assign o_Dout_Valid = state_q == HOLD;
  assign acc = i_Byte_Valid & o_Byte_Ready;
  // Byte 0 sits in row 0 so its position is mode-independent; i_Inv is used live only then
  assign we_d = acc ? 16'(1) << sr_pos(cnt_q, cnt_q == 4'd0 ? i_Inv : mode_q) : 16'd0;
  for (genvar j = 0; j < AES_NB_BYTES; j++) begin : g_out
    assign o_Dout[127-8*j -: 8] = mem_q[j];
  end
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_q <= COLLECT;
      cnt_q <= 4'd0;
      mode_q <= 1'b0;
      for (int i = 0; i < AES_NB_BYTES; i++) mem_q[i] <= 8'h00;
    end else if (i_Clear) begin
      state_q <= COLLECT;
      cnt_q <= 4'd0;
    end else begin
      for (int i = 0; i < AES_NB_BYTES; i++) if (we_d[i]) mem_q[i] <= i_Byte;
      if (acc) begin
        cnt_q <= cnt_q + 4'd1;
        if (cnt_q == 4'd0) mode_q <= i_Inv;
        if (cnt_q == 4'(AES_NB_BYTES - 1)) state_q <= HOLD;
      end else if (state_q == HOLD && i_Dout_Ready) begin
        state_q <= COLLECT;
      end
    end
  end
endmodule

// File: tb/tb_aes_shift_rows_ser.sv
// tb_aes_shift_rows_ser: directed and random self-checking bench for the byte-serial ShiftRows unit
module tb_aes_shift_rows_ser;
  localparam logic [127:0] FWD = 128'h00050A0F_04090E03_080D0207_0C01060B;
  localparam logic [127:0] INV = 128'h000D0A07_04010E0B_0805020F_0C090603;
  logic         i_Clk = 0;
  logic         i_Rst = 1;
  logic         i_Clear = 0;
  logic         i_Byte_Valid = 0;
  logic [7:0]   i_Byte = 0;
  logic         i_Inv = 0;
  logic         o_Byte_Ready;
  logic [127:0] o_Dout;
  logic         o_Dout_Valid;
  logic         i_Dout_Ready = 1;
  int errors = 0;
  int checks = 0;
  logic [7:0] blk [16];
  logic [127:0] held;
  logic blk_inv;

  aes_shift_rows_ser dut (
    .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Clear(i_Clear), .i_Byte_Valid(i_Byte_Valid),
    .i_Byte(i_Byte), .i_Inv(i_Inv), .o_Byte_Ready(o_Byte_Ready), .o_Dout(o_Dout),
    .o_Dout_Valid(o_Dout_Valid), .i_Dout_Ready(i_Dout_Ready)
  );

  always #5 i_Clk = ~i_Clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: AES state as a 4x4 matrix, row r rotated left by r (forward) or right by r (inverse)
  function automatic logic [127:0] model(input logic inv);
    logic [127:0] m;
    int r, c, dc;
    m = '0;
    for (int k = 0; k < 16; k++) begin
      r = k % 4;
      c = k / 4;
      dc = inv ? (c + r) % 4 : (c - r + 4) % 4;
      m[127 - 8 * (r + 4 * dc) -: 8] = blk[k];
    end
    return m;
  endfunction

  task automatic send(input logic [7:0] b, input logic inv);
    int n;
    n = 0;
    i_Byte_Valid = 1;
    i_Byte = b;
    i_Inv = inv;
    while (!o_Byte_Ready && n < 100) begin
      @(negedge i_Clk);
      n++;
    end
    if (n >= 100) check("ready_timeout", 1, 0);
    @(negedge i_Clk);
    i_Byte_Valid = 0;
    i_Byte = 8'($urandom);
    i_Inv = 1'($urandom);
  endtask

  task automatic send_block(input logic inv, input int first, input int maxgap);
    for (int k = first; k < 16; k++) begin
      if (maxgap > 0) repeat ($urandom_range(0, maxgap)) @(negedge i_Clk);
      send(blk[k], k == 0 ? inv : 1'($urandom));
    end
  endtask

  task automatic check_done(input string tag, input logic [127:0] exp);
    check({tag, "_valid"}, 128'(o_Dout_Valid), 128'd1);
    check({tag, "_ready"}, 128'(o_Byte_Ready), 128'd0);
    check({tag, "_dout"}, o_Dout, exp);
  endtask

  task automatic check_released(input string tag);
    @(negedge i_Clk);
    check({tag, "_valid_drop"}, 128'(o_Dout_Valid), 128'd0);
    check({tag, "_ready_back"}, 128'(o_Byte_Ready), 128'd1);
  endtask

  task automatic ramp();
    for (int k = 0; k < 16; k++) blk[k] = 8'(k);
  endtask

  initial begin
    #23;
    check("rst_dout", o_Dout, 128'h0);
    check("rst_valid", 128'(o_Dout_Valid), 128'd0);
    check("rst_ready", 128'(o_Byte_Ready), 128'd1);
    @(negedge i_Clk);
    i_Rst = 0;
    @(negedge i_Clk);

    ramp();
    send_block(0, 0, 0);
    check_done("fwd", FWD);
    check_released("fwd");

    send_block(1, 0, 0);
    check_done("inv", INV);
    check_released("inv");

    // Backpressure: block completes, next block's first byte waits 10 cycles
    i_Dout_Ready = 0;
    send_block(0, 0, 0);
    check_done("bp", FWD);
    held = o_Dout;
    i_Byte_Valid = 1;
    i_Byte = 8'h00;
    i_Inv = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge i_Clk);
      check("bp_ready_low", 128'(o_Byte_Ready), 128'd0);
      check("bp_valid_high", 128'(o_Dout_Valid), 128'd1);
      check("bp_dout_stable", o_Dout, held);
    end
    i_Dout_Ready = 1;
    @(negedge i_Clk);
    check("bp_ready_after", 128'(o_Byte_Ready), 128'd1);
    check("bp_valid_after", 128'(o_Dout_Valid), 128'd0);
    send(8'h00, 1);
    send_block(1, 1, 0);
    check_done("bp_next", INV);
    check_released("bp_next");

    send_block(0, 0, 3);
    check_done("gaps", FWD);
    check_released("gaps");

    // Clear after byte 07, with a byte offered in the clear cycle
    for (int k = 0; k < 8; k++) send(blk[k], 1);
    i_Clear = 1;
    i_Byte_Valid = 1;
    i_Byte = 8'hEE;
    @(negedge i_Clk);
    i_Clear = 0;
    i_Byte_Valid = 0;
    check("clr_ready", 128'(o_Byte_Ready), 128'd1);
    send_block(0, 0, 0);
    check_done("clr_fwd", FWD);
    check_released("clr_fwd");

    // Clear while held
    i_Dout_Ready = 0;
    send_block(1, 0, 0);
    check_done("clr_hold", INV);
    i_Clear = 1;
    check_released("clr_hold");
    i_Clear = 0;
    i_Dout_Ready = 1;

    // Asynchronous reset after 9 bytes
    for (int k = 0; k < 9; k++) send(blk[k], 0);
    #2 i_Rst = 1;
    #1;
    check("arst_dout", o_Dout, 128'h0);
    check("arst_valid", 128'(o_Dout_Valid), 128'd0);
    check("arst_ready", 128'(o_Byte_Ready), 128'd1);
    @(negedge i_Clk);
    i_Rst = 0;
    send_block(0, 0, 0);
    check_done("arst_fwd", FWD);
    check_released("arst_fwd");

    // Random blocks against the matrix model
    for (int t = 0; t < 20; t++) begin
      for (int k = 0; k < 16; k++) blk[k] = 8'($urandom);
      blk_inv = 1'($urandom);
      i_Dout_Ready = 1'($urandom);
      send_block(blk_inv, 0, 2);
      check_done("rand", model(blk_inv));
      repeat ($urandom_range(0, 3)) begin
        @(negedge i_Clk);
        check("rand_hold", o_Dout, model(blk_inv));
      end
      i_Dout_Ready = 1;
      @(negedge i_Clk);
      check("rand_release", 128'(o_Byte_Ready), 128'd1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
